// File: rtl/cpu_ad48_decode.sv
// Registered decode stage for cpu_ad48: turns 48-bit fetch words into execute control,
// with a main/skid register pair so in_ready can be registered without losing throughput.
module cpu_ad48_decode #(
    parameter int unsigned PC_W = 16
) (
    input  logic            clk,
    input  logic            resetn,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [47:0]     in_instr,
    input  logic [PC_W-1:0] in_pc,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [PC_W-1:0] out_pc,
    output logic [1:0]      out_class,
    output logic            out_dsel,
    output logic [2:0]      out_rd,
    output logic [2:0]      out_rs,
    output logic [2:0]      out_rt,
    output logic [3:0]      out_func,
    output logic            out_swap,
    output logic [47:0]     out_imm,
    output logic            out_we,
    output logic            out_halt
);

    localparam int unsigned INSTR_W = 48;
    localparam int unsigned IMM_W   = 27;

    localparam logic [3:0] OP_ALU    = 4'h1;
    localparam logic [3:0] OP_ALUI_A = 4'h2;
    localparam logic [3:0] OP_ALUI_D = 4'h3;
    localparam logic [3:0] OP_SYS    = 4'hF;

    localparam logic [1:0] CLS_ALU     = 2'd0;
    localparam logic [1:0] CLS_ALUI    = 2'd1;
    localparam logic [1:0] CLS_SYS     = 2'd2;
    localparam logic [1:0] CLS_ILLEGAL = 2'd3;

    typedef struct packed {
        logic [PC_W-1:0]    pc;
        logic [1:0]         cls;
        logic               dsel;
        logic [2:0]         rd;
        logic [2:0]         rs;
        logic [2:0]         rt;
        logic [3:0]         func;
        logic               swap;
        logic [INSTR_W-1:0] imm;
        logic               we;
        logic               halt;
    } bundle_t;

    bundle_t dec_c;
    bundle_t m_q, m_d;
    bundle_t s_q, s_d;
    logic    m_valid_q, m_valid_d;
    logic    s_valid_q, s_valid_d;
    logic    halted_q, halted_d;
    logic    in_ready_q, in_ready_d;
    logic    accept_c;

    // Bits [28:27] carry no field in any format.
    logic unused_instr_bits;
    assign unused_instr_bits = ^in_instr[28:27];

    // Field extraction; A0 is hard-wired so writes to it are suppressed.
    always_comb begin
        dec_c    = '0;
        dec_c.pc = in_pc;
        case (in_instr[47:44])
            OP_ALU: begin
                dec_c.cls  = CLS_ALU;
                dec_c.dsel = in_instr[43];
                dec_c.rd   = in_instr[42:40];
                dec_c.rs   = in_instr[39:37];
                dec_c.rt   = in_instr[36:34];
                dec_c.func = in_instr[33:30];
                dec_c.swap = in_instr[29];
                dec_c.we   = dec_c.dsel || (dec_c.rd != 3'd0);
            end
            OP_ALUI_A, OP_ALUI_D: begin
                dec_c.cls  = CLS_ALUI;
                dec_c.dsel = (in_instr[47:44] == OP_ALUI_D);
                dec_c.rd   = in_instr[42:40];
                dec_c.rs   = in_instr[39:37];
                dec_c.func = in_instr[33:30];
                dec_c.imm  = {{(INSTR_W-IMM_W){in_instr[IMM_W-1]}}, in_instr[IMM_W-1:0]};
                dec_c.we   = dec_c.dsel || (dec_c.rd != 3'd0);
            end
            OP_SYS: begin
                dec_c.cls  = CLS_SYS;
                dec_c.halt = (in_instr[3:0] == 4'hF);
            end
            default: begin
                dec_c.cls  = CLS_ILLEGAL;
            end
        endcase
    end

    // Main/skid storage: M drains first, S only fills while M is stalled.
    always_comb begin
        accept_c  = in_valid && in_ready_q && !flush;
        m_d       = m_q;
        s_d       = s_q;
        m_valid_d = m_valid_q;
        s_valid_d = s_valid_q;
        halted_d  = halted_q;
        if (flush) begin
            m_valid_d = 1'b0;
            s_valid_d = 1'b0;
            halted_d  = 1'b0;
        end else begin
            if (out_ready && m_valid_q) begin
                if (s_valid_q) begin
                    m_d       = s_q;
                    s_valid_d = 1'b0;
                end else begin
                    m_valid_d = accept_c;
                    if (accept_c) begin
                        m_d = dec_c;
                    end
                end
            end else if (accept_c) begin
                if (m_valid_q) begin
                    s_d       = dec_c;
                    s_valid_d = 1'b1;
                end else begin
                    m_d       = dec_c;
                    m_valid_d = 1'b1;
                end
            end
            if (accept_c && dec_c.halt) begin
                halted_d = 1'b1;
            end
        end
        in_ready_d = !s_valid_d && !halted_d;
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            m_q        <= '0;
            s_q        <= '0;
            m_valid_q  <= 1'b0;
            s_valid_q  <= 1'b0;
            halted_q   <= 1'b0;
            in_ready_q <= 1'b0;
        end else begin
            m_q        <= m_d;
            s_q        <= s_d;
            m_valid_q  <= m_valid_d;
            s_valid_q  <= s_valid_d;
            halted_q   <= halted_d;
            in_ready_q <= in_ready_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = m_valid_q;
    assign out_pc    = m_q.pc;
    assign out_class = m_q.cls;
    assign out_dsel  = m_q.dsel;
    assign out_rd    = m_q.rd;
    assign out_rs    = m_q.rs;
    assign out_rt    = m_q.rt;
    assign out_func  = m_q.func;
    assign out_swap  = m_q.swap;
    assign out_imm   = m_q.imm;
    assign out_we    = m_q.we;
    assign out_halt  = m_q.halt;

endmodule
